// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Forwarding select encodings
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        LU_STALL,
        MDU_BUSY
    } state_e;

    // Down-counter width: must hold max(LOAD_LAT, MDU_LAT) - 2, never less than 1 bit
    function automatic int unsigned cnt_width(input int unsigned load_lat,
                                              input int unsigned mdu_lat);
        int unsigned m;
        m = (load_lat > mdu_lat) ? load_lat : mdu_lat;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
// master = pipeline (drives register addresses/controls), slave = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned CNT_W   = 16
);
    logic [NUM_SRC*REG_AW-1:0] id_src_addr;
    logic [NUM_SRC-1:0]        id_src_used;
    logic [NUM_SRC*REG_AW-1:0] ex_src_addr;
    logic [REG_AW-1:0]         ex_dst_addr;
    logic                      ex_reg_write;
    logic                      ex_mem_read;
    logic [REG_AW-1:0]         mem_dst_addr;
    logic                      mem_reg_write;
    logic                      mem_mem_read;
    logic [REG_AW-1:0]         wb_dst_addr;
    logic                      wb_reg_write;
    logic                      mdu_start;
    logic                      branch_taken;

    logic                      stall_if;
    logic                      stall_id;
    logic                      stall_ex;
    logic                      bubble_ex;
    logic                      bubble_mem;
    logic                      flush_id;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic                      busy;
    logic [CNT_W-1:0]          stall_count;

    modport master (
        output id_src_addr, id_src_used, ex_src_addr, ex_dst_addr, ex_reg_write,
               ex_mem_read, mem_dst_addr, mem_reg_write, mem_mem_read,
               wb_dst_addr, wb_reg_write, mdu_start, branch_taken,
        input  stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush_id,
               fwd_sel, busy, stall_count
    );

    modport slave (
        input  id_src_addr, id_src_used, ex_src_addr, ex_dst_addr, ex_reg_write,
               ex_mem_read, mem_dst_addr, mem_reg_write, mem_mem_read,
               wb_dst_addr, wb_reg_write, mdu_start, branch_taken,
        output stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush_id,
               fwd_sel, busy, stall_count
    );

endinterface

// File: rtl/hazard_ctrl_fwd_sel_unit.sv
// Forwarding select for one EX-stage source operand; EX/MEM beats MEM/WB.
module fwd_sel_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_addr_i,
    input  logic [REG_AW-1:0] mem_dst_addr_i,
    input  logic              mem_reg_write_i,
    input  logic              mem_mem_read_i,
    input  logic [REG_AW-1:0] wb_dst_addr_i,
    input  logic              wb_reg_write_i,
    output logic [1:0]        sel_o
);

    // Load results are not yet available in EX/MEM, so a load there never forwards
    always_comb begin
        sel_o = FWD_RF;
        if (mem_reg_write_i && !mem_mem_read_i && (mem_dst_addr_i != '0) &&
            (mem_dst_addr_i == src_addr_i)) begin
            sel_o = FWD_MEM;
        end else if (wb_reg_write_i && (wb_dst_addr_i != '0) &&
                     (wb_dst_addr_i == src_addr_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and MDU stalls, branch flush,
// operand forwarding selects and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MDU_LAT  = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    localparam int unsigned   CW       = cnt_width(LOAD_LAT, MDU_LAT);
    localparam logic [CW-1:0] LU_INIT  = (LOAD_LAT > 1) ? CW'(LOAD_LAT - 2) : '0;
    localparam logic [CW-1:0] MDU_INIT = CW'(MDU_LAT - 2);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic                 lu_match;
    logic                 stall_if, stall_id, stall_ex;
    logic                 bubble_ex, bubble_mem, flush_id;
    logic [NUM_SRC*2-1:0] fwd_raw;

    // Load in EX whose destination is read by a used operand of the ID instruction
    always_comb begin
        lu_match = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (hz.id_src_used[i] &&
                (hz.id_src_addr[i*REG_AW +: REG_AW] == hz.ex_dst_addr)) begin
                lu_match = 1'b1;
            end
        end
        lu_match = lu_match & hz.ex_mem_read & hz.ex_reg_write &
                   (hz.ex_dst_addr != '0);
    end

    // Next state and stall/bubble/flush outputs; everything held low during reset
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        bubble_ex  = 1'b0;
        bubble_mem = 1'b0;
        flush_id   = 1'b0;
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (hz.branch_taken) begin
                        flush_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (hz.mdu_start) begin
                        stall_if   = 1'b1;
                        stall_id   = 1'b1;
                        stall_ex   = 1'b1;
                        bubble_mem = 1'b1;
                        state_d    = MDU_BUSY;
                        cnt_d      = MDU_INIT;
                    end else if (lu_match) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = LU_STALL;
                            cnt_d   = LU_INIT;
                        end
                    end
                end
                LU_STALL: begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - CW'(1);
                end
                MDU_BUSY: begin
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    stall_ex   = 1'b1;
                    bubble_mem = 1'b1;
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - CW'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Saturating count of front-end stall cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_if && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // State, latency counter and stall counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
        fwd_sel_unit #(
            .REG_AW(REG_AW)
        ) u_fwd (
            .src_addr_i      (hz.ex_src_addr[g*REG_AW +: REG_AW]),
            .mem_dst_addr_i  (hz.mem_dst_addr),
            .mem_reg_write_i (hz.mem_reg_write),
            .mem_mem_read_i  (hz.mem_mem_read),
            .wb_dst_addr_i   (hz.wb_dst_addr),
            .wb_reg_write_i  (hz.wb_reg_write),
            .sel_o           (fwd_raw[g*2 +: 2])
        );
    end

    assign hz.stall_if    = stall_if;
    assign hz.stall_id    = stall_id;
    assign hz.stall_ex    = stall_ex;
    assign hz.bubble_ex   = bubble_ex;
    assign hz.bubble_mem  = bubble_mem;
    assign hz.flush_id    = flush_id;
    assign hz.fwd_sel     = reset ? '0 : fwd_raw;
    assign hz.busy        = !reset && (state_q != IDLE);
    assign hz.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_LAT=1/MDU_LAT=4/CNT_W=16 and
// LOAD_LAT=3/MDU_LAT=2/CNT_W=4), each tracked by a remaining-stall-cycles model.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [9:0] id_src;
        logic [1:0] id_used;
        logic [9:0] ex_src;
        logic [4:0] ex_dst;
        logic       ex_rw;
        logic       ex_mr;
        logic [4:0] mem_dst;
        logic       mem_rw;
        logic       mem_mr;
        logic [4:0] wb_dst;
        logic       wb_rw;
        logic       mdu;
        logic       br;
    } in_t;

    // bit order: stall_if stall_id stall_ex bubble_ex bubble_mem flush_id busy
    typedef struct packed {
        logic stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush_id, busy;
    } ctl_t;

    typedef struct packed {
        in_t        in;
        ctl_t       ctl;
        logic [3:0] fwd;
    } vec_t;

    localparam ctl_t C_NONE  = 7'b0000000;
    localparam ctl_t C_LU    = 7'b1101000;
    localparam ctl_t C_LU_B  = 7'b1101001;
    localparam ctl_t C_MDU   = 7'b1110100;
    localparam ctl_t C_MDU_B = 7'b1110101;
    localparam ctl_t C_BR    = 7'b0001010;

    logic        clk = 1'b0;
    in_t         vin [2];
    ctl_t        act [2];
    logic [3:0]  afwd [2];
    logic [31:0] asc [2];
    int          tests = 0;
    int          fails = 0;

    // reference model state: remaining stall cycles after the current one
    int rem [2];
    bit mmode [2];
    int scnt [2];
    bit mvalid [2];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(16)) if1 ();
    hazard_ctrl_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(4))  if3 ();

    hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .MDU_LAT(4), .CNT_W(16)) dut1 (
        .clk(clk), .reset(vin[0].rst), .hz(if1)
    );
    hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3), .MDU_LAT(2), .CNT_W(4)) dut3 (
        .clk(clk), .reset(vin[1].rst), .hz(if3)
    );

    assign if1.id_src_addr   = vin[0].id_src;
    assign if1.id_src_used   = vin[0].id_used;
    assign if1.ex_src_addr   = vin[0].ex_src;
    assign if1.ex_dst_addr   = vin[0].ex_dst;
    assign if1.ex_reg_write  = vin[0].ex_rw;
    assign if1.ex_mem_read   = vin[0].ex_mr;
    assign if1.mem_dst_addr  = vin[0].mem_dst;
    assign if1.mem_reg_write = vin[0].mem_rw;
    assign if1.mem_mem_read  = vin[0].mem_mr;
    assign if1.wb_dst_addr   = vin[0].wb_dst;
    assign if1.wb_reg_write  = vin[0].wb_rw;
    assign if1.mdu_start     = vin[0].mdu;
    assign if1.branch_taken  = vin[0].br;

    assign if3.id_src_addr   = vin[1].id_src;
    assign if3.id_src_used   = vin[1].id_used;
    assign if3.ex_src_addr   = vin[1].ex_src;
    assign if3.ex_dst_addr   = vin[1].ex_dst;
    assign if3.ex_reg_write  = vin[1].ex_rw;
    assign if3.ex_mem_read   = vin[1].ex_mr;
    assign if3.mem_dst_addr  = vin[1].mem_dst;
    assign if3.mem_reg_write = vin[1].mem_rw;
    assign if3.mem_mem_read  = vin[1].mem_mr;
    assign if3.wb_dst_addr   = vin[1].wb_dst;
    assign if3.wb_reg_write  = vin[1].wb_rw;
    assign if3.mdu_start     = vin[1].mdu;
    assign if3.branch_taken  = vin[1].br;

    assign act[0]  = {if1.stall_if, if1.stall_id, if1.stall_ex, if1.bubble_ex,
                      if1.bubble_mem, if1.flush_id, if1.busy};
    assign act[1]  = {if3.stall_if, if3.stall_id, if3.stall_ex, if3.bubble_ex,
                      if3.bubble_mem, if3.flush_id, if3.busy};
    assign afwd[0] = if1.fwd_sel;
    assign afwd[1] = if3.fwd_sel;
    assign asc[0]  = 32'(if1.stall_count);
    assign asc[1]  = 32'(if3.stall_count);

    function automatic bit lu_match(input in_t v);
        bit m;
        m = 1'b0;
        for (int i = 0; i < 2; i++)
            if (v.id_used[i] && (v.id_src[i*5 +: 5] == v.ex_dst)) m = 1'b1;
        return m && v.ex_mr && v.ex_rw && (v.ex_dst != 5'd0);
    endfunction

    // Expected control outputs of instance k for the current cycle
    function automatic ctl_t mctl(input int k, input in_t v);
        ctl_t c;
        c = C_NONE;
        if (v.rst) return c;
        if (rem[k] > 0) c = mmode[k] ? C_MDU_B : C_LU_B;
        else if (v.br) c = C_BR;
        else if (v.mdu) c = C_MDU;
        else if (lu_match(v)) c = C_LU;
        return c;
    endfunction

    function automatic logic [3:0] mfwd(input in_t v);
        logic [3:0] f;
        logic [4:0] a;
        f = 4'b0000;
        if (v.rst) return f;
        for (int i = 0; i < 2; i++) begin
            a = v.ex_src[i*5 +: 5];
            if (v.mem_rw && !v.mem_mr && v.mem_dst != 5'd0 && v.mem_dst == a) f[i*2 +: 2] = 2'b01;
            else if (v.wb_rw && v.wb_dst != 5'd0 && v.wb_dst == a)          f[i*2 +: 2] = 2'b10;
        end
        return f;
    endfunction

    task automatic mupdate(input int k, input in_t v);
        ctl_t c;
        int   smax;
        c    = mctl(k, v);
        smax = (k == 0) ? 65535 : 15;
        if (v.rst) begin
            rem[k]    = 0;
            scnt[k]   = 0;
            mvalid[k] = 1'b1;
        end else begin
            if (c.stall_if && scnt[k] < smax) scnt[k] = scnt[k] + 1;
            if (rem[k] > 0) rem[k] = rem[k] - 1;
            else if (!v.br && v.mdu) begin
                rem[k]   = ((k == 0) ? 4 : 2) - 1;
                mmode[k] = 1'b1;
            end else if (!v.br && lu_match(v)) begin
                rem[k]   = ((k == 0) ? 1 : 3) - 1;
                mmode[k] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Compare both instances with the model, then clock and update the model
    task automatic advance();
        for (int k = 0; k < 2; k++) begin
            chk((k == 0) ? "d1_ctl" : "d3_ctl", 32'(act[k]), 32'(mctl(k, vin[k])));
            chk((k == 0) ? "d1_fwd" : "d3_fwd", 32'(afwd[k]), 32'(mfwd(vin[k])));
            if (mvalid[k]) chk((k == 0) ? "d1_cnt" : "d3_cnt", asc[k], 32'(scnt[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) mupdate(k, vin[k]);
        #1;
    endtask

    task automatic reset_dut(input int k);
        vin[0] = '0;
        vin[1] = '0;
        vin[k].rst = 1'b1;
        settle();
        chk("rst_ctl", 32'(act[k]), 32'(C_NONE));
        advance();
        vin[k] = '0;
    endtask

    // Inputs that the controller must ignore outside IDLE are never driven there
    always @(posedge clk) begin
        if (!vin[0].rst && if1.busy)
            assert (!(vin[0].br || vin[0].mdu || lu_match(vin[0])))
                else $error("dut1 request while busy");
        if (!vin[1].rst && if3.busy)
            assert (!(vin[1].br || vin[1].mdu || lu_match(vin[1])))
                else $error("dut3 request while busy");
    end

    vec_t tbl [$];

    task automatic add(input in_t v, input ctl_t c, input logic [3:0] f);
        vec_t e;
        e.in  = v;
        e.ctl = c;
        e.fwd = f;
        tbl.push_back(e);
    endtask

    initial begin
        in_t v, lu;
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; mmode[k] = 0; scnt[k] = 0; mvalid[k] = 0;
        end

        // power-on reset with forwarding-matching inputs: everything must stay 0
        vin[0] = '0; vin[1] = '0;
        vin[0].rst = 1'b1; vin[1].rst = 1'b1;
        vin[0].mem_dst = 5'd5; vin[0].mem_rw = 1'b1; vin[0].ex_src = {5'd0, 5'd5};
        settle(); advance();
        settle();
        chk("reset_fwd", 32'(afwd[0]), 32'd0);
        chk("reset_busy", 32'(act[0].busy), 32'd0);
        advance();
        vin[0] = '0; vin[1] = '0;

        // single-cycle vectors on the LOAD_LAT=1 instance
        lu = '0; lu.id_src = {5'd7, 5'd3}; lu.id_used = 2'b11;
        lu.ex_dst = 5'd3; lu.ex_rw = 1'b1; lu.ex_mr = 1'b1;
        add(lu, C_LU, 4'b0000);
        v = lu; v.br = 1'b1;                                   add(v, C_BR, 4'b0000);
        v = lu; v.ex_dst = 5'd0; v.id_src = {5'd7, 5'd0};      add(v, C_NONE, 4'b0000);
        v = lu; v.id_src = {5'd3, 5'd4}; v.id_used = 2'b01;    add(v, C_NONE, 4'b0000);
        v = lu; v.id_src = {5'd3, 5'd4}; v.id_used = 2'b10;    add(v, C_LU, 4'b0000);
        v = lu; v.ex_mr = 1'b0;                                add(v, C_NONE, 4'b0000);
        v = lu; v.ex_rw = 1'b0;                                add(v, C_NONE, 4'b0000);
        v = '0; v.mem_dst = 5'd5; v.mem_rw = 1'b1; v.wb_dst = 5'd5; v.wb_rw = 1'b1;
        v.ex_src = {5'd0, 5'd5};                               add(v, C_NONE, 4'b0001);
        v.mem_mr = 1'b1;                                       add(v, C_NONE, 4'b0010);
        v = '0; v.mem_rw = 1'b1; v.wb_rw = 1'b1;               add(v, C_NONE, 4'b0000);
        v = '0; v.mem_dst = 5'd5; v.mem_rw = 1'b1; v.wb_dst = 5'd9; v.wb_rw = 1'b1;
        v.ex_src = {5'd9, 5'd5};                               add(v, C_NONE, 4'b1001);
        v = '0; v.mem_dst = 5'd5; v.wb_dst = 5'd5; v.wb_rw = 1'b1;
        v.ex_src = {5'd5, 5'd5};                               add(v, C_NONE, 4'b1010);
        v = '0; v.wb_dst = 5'd5; v.ex_src = {5'd0, 5'd5};      add(v, C_NONE, 4'b0000);
        v = lu; v.mem_dst = 5'd5; v.mem_rw = 1'b1; v.ex_src = {5'd5, 5'd0};
        add(v, C_LU, 4'b0100);

        foreach (tbl[i]) begin
            vin[0] = tbl[i].in;
            vin[1] = '0;
            settle();
            chk($sformatf("tbl_ctl[%0d]", i), 32'(act[0]), 32'(tbl[i].ctl));
            chk($sformatf("tbl_fwd[%0d]", i), 32'(afwd[0]), 32'(tbl[i].fwd));
            advance();
        end

        // lw $3 / add using $3, LOAD_LAT=1: one stall, then WB forwarding two cycles later
        reset_dut(0);
        v = '0; v.id_src = {5'd0, 5'd3}; v.id_used = 2'b01;
        v.ex_dst = 5'd3; v.ex_rw = 1'b1; v.ex_mr = 1'b1;
        vin[0] = v; settle(); chk("ll1_c0", 32'(act[0]), 32'(C_LU)); advance();
        v = '0; v.id_src = {5'd0, 5'd3}; v.id_used = 2'b01;
        v.mem_dst = 5'd3; v.mem_rw = 1'b1; v.mem_mr = 1'b1;
        vin[0] = v; settle(); chk("ll1_c1", 32'(act[0]), 32'(C_NONE)); advance();
        v = '0; v.ex_src = {5'd0, 5'd3}; v.wb_dst = 5'd3; v.wb_rw = 1'b1;
        vin[0] = v; settle();
        chk("ll1_fwd", 32'(afwd[0]), 32'b0010);
        chk("ll1_c2", 32'(act[0]), 32'(C_NONE));
        advance();

        // LOAD_LAT=3: three stall cycles, busy on cycles 2-3; destination $0 never stalls
        reset_dut(1);
        v = '0; v.id_src = {5'd0, 5'd3}; v.id_used = 2'b01;
        v.ex_dst = 5'd3; v.ex_rw = 1'b1; v.ex_mr = 1'b1;
        vin[1] = v; settle(); chk("ll3_c0", 32'(act[1]), 32'(C_LU)); advance();
        vin[1] = '0;
        for (int c = 1; c < 3; c++) begin
            settle(); chk($sformatf("ll3_c%0d", c), 32'(act[1]), 32'(C_LU_B)); advance();
        end
        settle();
        chk("ll3_end", 32'(act[1]), 32'(C_NONE));
        chk("ll3_cnt", asc[1], 32'd3);
        advance();
        v = '0; v.id_used = 2'b11; v.ex_rw = 1'b1; v.ex_mr = 1'b1;
        vin[1] = v; settle(); chk("ll3_r0", 32'(act[1]), 32'(C_NONE)); advance();

        // MDU_LAT=4: four stall cycles in total, counter +4
        reset_dut(0);
        vin[0].mdu = 1'b1; settle(); chk("mdu_c0", 32'(act[0]), 32'(C_MDU)); advance();
        vin[0] = '0;
        for (int c = 1; c < 4; c++) begin
            settle(); chk($sformatf("mdu_c%0d", c), 32'(act[0]), 32'(C_MDU_B)); advance();
        end
        settle();
        chk("mdu_end", 32'(act[0]), 32'(C_NONE));
        chk("mdu_cnt", asc[0], 32'd4);
        advance();

        // branch coincident with load-use: flush only, stall counter untouched
        reset_dut(0);
        vin[0] = lu; vin[0].br = 1'b1;
        settle(); chk("br_c0", 32'(act[0]), 32'(C_BR)); advance();
        vin[0] = '0;
        settle();
        chk("br_c1", 32'(act[0]), 32'(C_NONE));
        chk("br_cnt", asc[0], 32'd0);
        advance();

        // reset in LU_STALL cycle 2: outputs drop at once, IDLE afterwards
        reset_dut(1);
        vin[1] = lu; settle(); chk("rms_c0", 32'(act[1]), 32'(C_LU)); advance();
        vin[1] = '0; settle(); chk("rms_c1", 32'(act[1]), 32'(C_LU_B)); advance();
        v = '0; v.rst = 1'b1; v.mem_dst = 5'd5; v.mem_rw = 1'b1; v.ex_src = {5'd5, 5'd5};
        vin[1] = v; settle();
        chk("rms_ctl", 32'(act[1]), 32'(C_NONE));
        chk("rms_fwd", 32'(afwd[1]), 32'd0);
        advance();
        vin[1] = '0; settle();
        chk("rms_idle", 32'(act[1]), 32'(C_NONE));
        chk("rms_cnt", asc[1], 32'd0);
        advance();

        // saturation with CNT_W=4 via back-to-back MDU_LAT=2 operations (20 stall cycles)
        reset_dut(1);
        for (int c = 0; c < 20; c++) begin
            vin[1] = '0;
            vin[1].mdu = (c % 2 == 0);
            settle();
            chk("sat_ctl", 32'(act[1]), 32'((c % 2 == 0) ? C_MDU : C_MDU_B));
            advance();
        end
        vin[1] = '0; settle();
        chk("sat_cnt", asc[1], 32'd15);
        chk("sat_idle", 32'(act[1]), 32'(C_NONE));
        advance();

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                v         = '0;
                v.rst     = ($urandom_range(0, 49) == 0);
                v.id_src  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
                v.id_used = 2'($urandom_range(0, 3));
                v.ex_src  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
                v.ex_dst  = 5'($urandom_range(0, 3));
                v.ex_rw   = 1'($urandom_range(0, 1));
                v.ex_mr   = 1'($urandom_range(0, 1));
                v.mem_dst = 5'($urandom_range(0, 3));
                v.mem_rw  = 1'($urandom_range(0, 1));
                v.mem_mr  = 1'($urandom_range(0, 1));
                v.wb_dst  = 5'($urandom_range(0, 3));
                v.wb_rw   = 1'($urandom_range(0, 1));
                v.mdu     = ($urandom_range(0, 9) == 0);
                v.br      = ($urandom_range(0, 7) == 0);
                if (rem[k] > 0) begin
                    v.br = 1'b0; v.mdu = 1'b0; v.ex_mr = 1'b0;
                end
                vin[k] = v;
            end
            settle();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core. It sits beside the ID and EX stages and does four jobs: detects load-use hazards and stalls for a configurable memory latency, stalls the front end for multi-cycle MDU (mul/div) operations, flushes on taken branches, and drives the per-operand forwarding selects. It also keeps a saturating count of stall cycles for performance analysis.

## Interface
- `REG_AW`, 5, register address width
- `NUM_SRC`, 2, source operands per instruction
- `LOAD_LAT`, 1, load-use stall cycles (1..4)
- `MDU_LAT`, 4, MDU occupancy in cycles (2..32)
- `CNT_W`, 16, width of the stall counter

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `id_src_addr`  in  NUM_SRC*REG_AW  source register addresses in IF/ID; operand i is at bits [i*REG_AW +: REG_AW]
- `id_src_used`  in  NUM_SRC  operand i is actually read
- `ex_src_addr`  in  NUM_SRC*REG_AW  source register addresses in ID/EX, used for forwarding
- `ex_dst_addr`  in  REG_AW  destination register in ID/EX
- `ex_reg_write`  in  1  ID/EX writes a register
- `ex_mem_read`  in  1  ID/EX is a load
- `mem_dst_addr`, `mem_reg_write`, `mem_mem_read`  in  REG_AW/1/1  EX/MEM equivalents
- `wb_dst_addr`, `wb_reg_write`  in  REG_AW/1  MEM/WB equivalents
- `mdu_start`  in  1  EX instruction starts an MDU operation
- `branch_taken`  in  1  branch resolved taken in EX
- `stall_if`  out  1  hold PC
- `stall_id`  out  1  hold IF/ID
- `stall_ex`  out  1  hold ID/EX
- `bubble_ex`  out  1  load NOP into ID/EX
- `bubble_mem`  out  1  load NOP into EX/MEM
- `flush_id`  out  1  load NOP into IF/ID
- `fwd_sel`  out  NUM_SRC*2  per-operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
- `busy`  out  1  state is not IDLE
- `stall_count`  out  CNT_W  saturating count of cycles with `stall_if`=1

## Operation
- **States:** IDLE, LU_STALL, MDU_BUSY. A down-counter `cnt` is sized to cover max(LOAD_LAT, MDU_LAT).
- **Load-use match:** `ex_mem_read` & `ex_reg_write` & `ex_dst_addr`≠0 & there exists i with `id_src_used[i]` and `id_src_addr[i]`==`ex_dst_addr`.
- **Priority in IDLE:** branch_taken > mdu_start > load-use.
  - **branch_taken:** `flush_id`=1, `bubble_ex`=1. No stall. Any load-use match is suppressed.
  - **mdu_start:** `stall_if`, `stall_id`, `stall_ex` and `bubble_mem` are asserted this cycle. Go to MDU_BUSY with `cnt`=MDU_LAT-2. If MDU_LAT==2, return to IDLE next cycle with the stall held one more cycle.
  - **load-use:** `stall_if`, `stall_id` and `bubble_ex` are asserted. If LOAD_LAT==1, stay in IDLE. Otherwise go to LU_STALL with `cnt`=LOAD_LAT-2.
- **LU_STALL:** `stall_if`, `stall_id` and `bubble_ex` are asserted every cycle. When `cnt`==0, go to IDLE; otherwise decrement.
- **MDU_BUSY:** `stall_if`, `stall_id`, `stall_ex` and `bubble_mem` are asserted every cycle. When `cnt`==0, go to IDLE; otherwise decrement.
- **Inputs ignored outside IDLE:** `branch_taken`, `mdu_start` and load-use matches. Asserting them there is a bench assertion failure.
- **Forwarding:** purely combinational and computed in every state, per operand i:
  - 01 if `mem_reg_write` & !`mem_mem_read` & `mem_dst_addr`≠0 & `mem_dst_addr`==`ex_src_addr[i]`;
  - else 10 if `wb_reg_write` & `wb_dst_addr`≠0 & match;
  - else 00.
  - EX/MEM always wins over MEM/WB.
- **Regfile requirement:** the regfile provides write-before-read bypass, so operands re-read during LOAD_LAT>1 stalls are correct.
- **stall_count:** increments on every cycle with `stall_if`=1 and saturates at all-ones.

## Timing
- All stall, bubble and flush outputs are combinational from the state and current inputs. The state, `cnt` and `stall_count` are registered on the `clk` rising edge.
- Load-use stalls last exactly LOAD_LAT cycles. MDU stalls last exactly MDU_LAT-1 cycles after the start cycle, MDU_LAT cycles in total.
- **Reset:** takes priority over everything. The state goes to IDLE, `cnt`=0 and `stall_count`=0. While `reset`=1, all stall, bubble and flush outputs are 0, `fwd_sel`=0 and `busy`=0.
- **Reset mid-stall:** stall outputs fall to 0 in the same cycle; the first cycle after reset is IDLE.

## Structure
- **Package `hazard_pkg`:**
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - state enum IDLE/LU_STALL/MDU_BUSY;
  - a function returning the counter width.
- **Sub-module `fwd_sel_unit`:** per-operand forwarding compare, instantiated NUM_SRC times by generate. The FSM, counter and stall logic stay in `hazard_ctrl`.

## Test plan
- **Load-use, LOAD_LAT=1:** `lw $3` in EX, `add` using $3 in ID. Expect `stall_if`/`stall_id`/`bubble_ex`=1 for 1 cycle, `busy` stays 0, and `fwd_sel` for $3 = 10 two cycles later.
- **Load-use, LOAD_LAT=3, and $0:** same stimulus gives exactly 3 stall cycles and `busy`=1 for cycles 2–3. A repeat with destination $0 gives no stall.
- **MDU_LAT=4:** `mdu_start` gives `stall_ex`/`bubble_mem`=1 for 4 cycles, then IDLE, and `stall_count` increases by 4.
- **Branch over load-use:** `branch_taken` coincident with a load-use match gives `flush_id`=`bubble_ex`=1, no stall, and `stall_count` unchanged.
- **Forwarding priority:** `mem_dst`=`wb_dst`=$5=`ex_src[0]` gives 01. Setting `mem_mem_read`=1 gives 10. An unused operand matching `ex_dst` in the load case gives no stall.
- **Reset and saturation:** assert `reset` in LU_STALL cycle 2 and expect all outputs 0 immediately, with IDLE next cycle. With CNT_W=4, 20 stall cycles leave `stall_count`=15.
